// File: rtl/apb_pkg.sv
// Shared types and default constants for the APB bridge (apb_bridge_n / apb_wait_timer).
package apb_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_NUM_SLV     = 4;
    localparam int unsigned DEF_WAIT_W      = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } apb_state_t;

    // Select-field width; a single slave still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase counter: saturating wait count with threshold compare and an
// optional timeout, compiled in only when APB_BRIDGE_TIMEOUT_EN is defined.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_W      = DEF_WAIT_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic [WAIT_W-1:0] i_wait_cycles,
    output logic              o_wait_met,
    output logic              o_timeout
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    assign o_wait_met = (r_count >= i_wait_cycles);

    if (TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("apb_wait_timer: TIMEOUT_CYC must be nonzero");
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_tcount;

    // Separate from r_count so the limit is independent of the WAIT_W saturation point.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_tcount <= '0;
        end else begin
            r_tcount <= r_tcount + TO_W'(1);
        end
    end

    assign o_timeout = (r_tcount == TO_W'(TIMEOUT_CYC - 1));
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/apb_bridge_n.sv
// Processor-to-APB bridge for NUM_SLV slaves: IDLE/SETUP/ACCESS/DONE sequencing.
// Optional ACCESS timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_bridge_n
    import apb_pkg::*;
#(
    parameter  int unsigned DATA_W      = DEF_DATA_W,
    parameter  int unsigned ADDR_W      = DEF_ADDR_W,
    parameter  int unsigned NUM_SLV     = DEF_NUM_SLV,
    parameter  int unsigned WAIT_W      = DEF_WAIT_W,
    parameter  int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int unsigned SEL_W       = sel_width(NUM_SLV)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      write,
    input  logic [SEL_W-1:0]          sel,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [WAIT_W-1:0]         wait_cycles,
    output logic [DATA_W-1:0]         rdata,
    output logic                      stable,
    output logic                      error,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata_vec,
    input  logic [NUM_SLV-1:0]        pready_vec,
    input  logic [NUM_SLV-1:0]        pslverr_vec
);

    apb_state_t r_state, w_state_nxt;

    logic              r_write;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;

    logic [NUM_SLV-1:0] w_onehot;
    logic               w_sel_ok;
    logic               w_pready;
    logic               w_pslverr;
    logic [DATA_W-1:0]  w_prdata;
    logic               w_wait_met;
    logic               w_timeout;
    logic               w_complete;
    logic               w_abort;

    // Out-of-range selects decode to an all-zero one-hot, which doubles as the validity flag.
    always_comb begin
        w_onehot  = '0;
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_pready    = pready_vec[i];
                w_pslverr   = pslverr_vec[i];
                w_prdata    = prdata_vec[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_ok = |w_onehot;

    apb_wait_timer #(
        .WAIT_W      (WAIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (r_state != ST_ACCESS),
        .i_wait_cycles (r_wait),
        .o_wait_met    (w_wait_met),
        .o_timeout     (w_timeout)
    );

    assign w_complete = (r_state == ST_ACCESS) && w_wait_met && w_pready;
    assign w_abort    = (r_state == ST_ACCESS) && w_timeout && !w_complete;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        psel        = '0;
        penable     = 1'b0;
        stable      = 1'b0;
        error       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                psel        = w_onehot;
                w_state_nxt = w_sel_ok ? ST_ACCESS : ST_DONE;
            end
            ST_ACCESS: begin
                psel    = w_onehot;
                penable = 1'b1;
                if (w_complete || w_abort) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                stable      = 1'b1;
                error       = r_error;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_write <= write;
                r_sel   <= sel;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_wait  <= wait_cycles;
            end
            if (w_complete) begin
                r_error <= w_pslverr;
                if (!r_write) r_rdata <= w_prdata;
            end else if (w_abort || (r_state == ST_SETUP && !w_sel_ok)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign rdata  = r_rdata;
    assign pwrite = r_write;
    assign paddr  = r_addr;
    assign pwdata = r_wdata;

endmodule

// File: tb/tb_apb_bridge_n.sv
// Self-checking bench for apb_bridge_n: directed vector table, corner sequences, random vs. reference model.
module tb_apb_bridge_n;

    localparam int TO_CYC = 64;

    logic        clk;
    logic        reset;
    logic        start, start3;
    logic        write;
    logic [1:0]  sel, sel3;
    logic [7:0]  addr, wdata, wait_cycles;
    logic [7:0]  rdata, rdata3;
    logic        stable, stable3, error, error3;
    logic [3:0]  psel;
    logic [2:0]  psel3;
    logic        penable, penable3, pwrite, pwrite3;
    logic [7:0]  paddr, paddr3, pwdata, pwdata3;
    logic [31:0] prdata_vec;
    logic [3:0]  pready_vec, pslverr_vec;
    logic [23:0] prdata_vec3;
    logic [2:0]  pready_vec3, pslverr_vec3;

    int errors = 0;
    int checks = 0;

    apb_bridge_n #(
        .DATA_W (8), .ADDR_W (8), .NUM_SLV (4), .WAIT_W (8), .TIMEOUT_CYC (TO_CYC)
    ) u_dut (
        .clk (clk), .reset (reset), .start (start), .write (write), .sel (sel),
        .addr (addr), .wdata (wdata), .wait_cycles (wait_cycles), .rdata (rdata),
        .stable (stable), .error (error), .psel (psel), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata_vec (prdata_vec),
        .pready_vec (pready_vec), .pslverr_vec (pslverr_vec)
    );

    apb_bridge_n #(
        .NUM_SLV (3)
    ) u_dut3 (
        .clk (clk), .reset (reset), .start (start3), .write (write), .sel (sel3),
        .addr (addr), .wdata (wdata), .wait_cycles (wait_cycles), .rdata (rdata3),
        .stable (stable3), .error (error3), .psel (psel3), .penable (penable3),
        .pwrite (pwrite3), .paddr (paddr3), .pwdata (pwdata3), .prdata_vec (prdata_vec3),
        .pready_vec (pready_vec3), .pslverr_vec (pslverr_vec3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] sel;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] wt;
        logic [7:0] prd;
        int         delay;
        logic       err;
        int         exp_lat;
        logic [3:0] exp_psel;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selected slave gets the given values; others drive contrasting data, ready and error.
    task automatic drive_slaves(input logic [1:0] s, input logic [7:0] prd, input logic rdy, input logic err);
        for (int i = 0; i < 4; i++) begin
            prdata_vec[i*8 +: 8] = (i == int'(s)) ? prd : ~prd;
            pready_vec[i]        = (i == int'(s)) ? rdy : 1'b1;
            pslverr_vec[i]       = (i == int'(s)) ? err : 1'b1;
        end
    endtask

    task automatic xfer(input string tag, input vec_t v);
        int c;
        int lat;
        bit bus_ok;
        write = v.wr; sel = v.sel; addr = v.addr; wdata = v.wdata; wait_cycles = v.wt;
        start = 1'b1;
        drive_slaves(v.sel, v.prd, 1'b0, v.err);
        tick();
        start = 1'b0;
        chk({tag, "_setup_psel"}, psel, v.exp_psel);
        chk({tag, "_setup_penable"}, penable, 1'b0);
        c = 1; lat = 0; bus_ok = 1'b1;
        while (lat == 0 && c < 400) begin
            if (stable === 1'b1) begin
                lat = c;
            end else begin
                if (psel !== v.exp_psel || penable !== (c >= 2) || paddr !== v.addr ||
                    pwrite !== v.wr || pwdata !== v.wdata) bus_ok = 1'b0;
                drive_slaves(v.sel, v.prd, (c >= 2) && (c - 2 >= v.delay), v.err);
                tick();
                c++;
            end
        end
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_bus_hold"}, bus_ok, 1'b1);
        if (lat != 0) begin
            chk({tag, "_error"}, error, v.exp_err);
            chk({tag, "_rdata"}, rdata, v.exp_rdata);
            tick();
            chk({tag, "_pulse_end"}, {stable, psel, penable}, 6'b0);
        end
        drive_slaves(v.sel, v.prd, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        vec_t v;
        bit   quiet;
        logic [7:0] exp_rdata;

        //           wr    sel    addr   wdata  wt     prd    dly err  lat  psel     err   rdata
        tbl[0] = '{1'b1, 2'd2, 8'h10, 8'hA5, 8'd0,  8'hEE, 0,  1'b0, 3,  4'b0100, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 2'd1, 8'h20, 8'h00, 8'd3,  8'h3C, 0,  1'b0, 6,  4'b0010, 1'b0, 8'h3C};
        tbl[2] = '{1'b0, 2'd0, 8'h30, 8'h00, 8'd0,  8'h77, 10, 1'b1, 13, 4'b0001, 1'b1, 8'h77};
        tbl[3] = '{1'b1, 2'd3, 8'h40, 8'h5A, 8'd2,  8'hEE, 5,  1'b0, 8,  4'b1000, 1'b0, 8'h77};
        tbl[4] = '{1'b0, 2'd3, 8'h41, 8'h00, 8'd5,  8'hC3, 1,  1'b0, 8,  4'b1000, 1'b0, 8'hC3};
        tbl[5] = '{1'b1, 2'd1, 8'h50, 8'h11, 8'd0,  8'hEE, 0,  1'b1, 3,  4'b0010, 1'b1, 8'hC3};
`ifdef APB_BRIDGE_TIMEOUT_EN
        tbl[6] = '{1'b0, 2'd2, 8'h60, 8'h00, 8'hFF, 8'h5A, 0,  1'b0, 66, 4'b0100, 1'b1, 8'hC3};
`else
        tbl[6] = '{1'b0, 2'd2, 8'h60, 8'h00, 8'hFF, 8'h5A, 0,  1'b0, 258, 4'b0100, 1'b0, 8'h5A};
`endif

        reset = 1'b1; start = 1'b0; start3 = 1'b0; write = 1'b1; sel = 2'd3; sel3 = 2'd0;
        addr = 8'hFF; wdata = 8'hFF; wait_cycles = 8'h00;
        drive_slaves(2'd0, 8'hFF, 1'b1, 1'b1);
        prdata_vec3 = 24'hEEEEEE; pready_vec3 = 3'b111; pslverr_vec3 = 3'b000;
        tick(); tick(); tick();
        reset = 1'b0;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_stable_error", {stable, error}, 2'b00);
        chk("rst_psel_penable", {psel, penable}, 5'b0);
        chk("rst_req_fields", {pwrite, paddr, pwdata}, 17'b0);

        // reset wins over a simultaneous start
        reset = 1'b1; start = 1'b1; sel = 2'd1; addr = 8'h77;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("rst_prio_psel", {psel, paddr}, 12'b0);
        tick();
        chk("rst_prio_idle", {psel, penable, stable}, 6'b0);

        for (int i = 0; i < 7; i++) begin
            xfer($sformatf("vec%0d", i), tbl[i]);
        end

        // reset during the ACCESS phase of a read
        write = 1'b0; sel = 2'd1; addr = 8'h55; wdata = 8'h00; wait_cycles = 8'd0; start = 1'b1;
        drive_slaves(2'd1, 8'h99, 1'b0, 1'b0);
        tick(); start = 1'b0;
        tick(); tick();
        chk("mid_penable", {psel, penable}, 5'b00101);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_outs", {rdata, stable, error, psel, penable, pwrite, paddr, pwdata}, 32'b0);
        drive_slaves(2'd1, 8'h99, 1'b1, 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (stable !== 1'b0 || psel !== 4'b0) quiet = 1'b0;
            tick();
        end
        chk("mid_no_pulse", quiet, 1'b1);
        v = '{1'b0, 2'd1, 8'h66, 8'h00, 8'd1, 8'h96, 0, 1'b0, 4, 4'b0010, 1'b0, 8'h96};
        xfer("recover", v);

        // slave never ready
`ifdef APB_BRIDGE_TIMEOUT_EN
        v = '{1'b0, 2'd0, 8'h70, 8'h00, 8'd0, 8'hAB, 100000, 1'b0, 66, 4'b0001, 1'b1, 8'h96};
`else
        v = '{1'b0, 2'd0, 8'h70, 8'h00, 8'd0, 8'hAB, 100000, 1'b0, 0, 4'b0001, 1'b0, 8'h96};
`endif
        xfer("hang", v);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("hang_rst_rdata", rdata, 8'h00);

        // out-of-range select on the three-slave instance
        write = 1'b0; addr = 8'h12; wdata = 8'h34; wait_cycles = 8'd0; sel3 = 2'd3; start3 = 1'b1;
        tick(); start3 = 1'b0;
        chk("inv_setup", {psel3, penable3, stable3, paddr3}, {3'b0, 1'b0, 1'b0, 8'h12});
        tick();
        chk("inv_done", {stable3, error3, psel3, penable3, rdata3}, {1'b1, 1'b1, 3'b0, 1'b0, 8'h00});
        tick();
        chk("inv_idle", {stable3, psel3}, 4'b0);

        // random transfers against a transaction-level model
        exp_rdata = 8'h00;
        drive_slaves(2'd0, 8'h00, 1'b0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            logic       w, rdy, err_c, done, exp_err, pen;
            logic [1:0] s;
            logic [7:0] a, d, wt, prd_c;
            logic [3:0] exp_psel;
            int         k, satk;
            w = 1'($urandom); s = 2'($urandom); a = 8'($urandom); d = 8'($urandom);
            wt = 8'($urandom_range(0, 4));
            exp_psel = 4'b0001 << s;
            write = w; sel = s; addr = a; wdata = d; wait_cycles = wt; start = 1'b1;
            tick();
            done = 1'b0; exp_err = 1'b0;
            for (int c = 1; c < 100 && !done; c++) begin
                pen = (c >= 2);
                chk("rnd_bus", {psel, penable, stable, pwrite, paddr, pwdata},
                    {exp_psel, pen, 1'b0, w, a, d});
                start = 1'($urandom); write = 1'($urandom); sel = 2'($urandom);
                addr = 8'($urandom); wdata = 8'($urandom); wait_cycles = 8'($urandom);
                rdy = 1'($urandom); err_c = 1'($urandom); prd_c = 8'($urandom);
                prdata_vec = $urandom; pready_vec = 4'($urandom); pslverr_vec = 4'($urandom);
                prdata_vec[int'(s)*8 +: 8] = prd_c;
                pready_vec[s] = rdy;
                pslverr_vec[s] = err_c;
                if (c >= 2) begin
                    k = c - 2;
                    satk = (k < 255) ? k : 255;
                    if (satk >= int'(wt) && rdy) begin
                        done = 1'b1; exp_err = err_c;
                        if (!w) exp_rdata = prd_c;
                    end
`ifdef APB_BRIDGE_TIMEOUT_EN
                    else if (k == TO_CYC - 1) begin
                        done = 1'b1; exp_err = 1'b1;
                    end
`endif
                end
                tick();
            end
            chk("rnd_completed", done, 1'b1);
            chk("rnd_done", {stable, error, psel, penable, rdata}, {1'b1, exp_err, 4'b0, 1'b0, exp_rdata});
            start = 1'($urandom); sel = 2'($urandom);
            tick();
            start = 1'b0;
            chk("rnd_idle", {stable, psel, penable}, 6'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_bridge_n.md
APB_BRIDGE_N -- requirements
Module: apb_bridge_n

Interface
REQ-001 Parameter DATA_W, default 8: APB and processor data width.
REQ-002 Parameter ADDR_W, default 8: address width.
REQ-003 Parameter NUM_SLV, default 4: slave count; SEL_W = $clog2(NUM_SLV), minimum 1.
REQ-004 Parameter WAIT_W, default 8: wait_cycles width.
REQ-005 Parameter TIMEOUT_CYC, default 64: ACCESS-cycle limit when timeout is compiled in.
REQ-006 Port clk, input, 1: one clock; all logic on posedge clk.
REQ-007 Port reset, input, 1: reset is synchronous and active-high.
REQ-008 Port start, input, 1: processor request strobe, sampled in IDLE only.
REQ-009 Port write, input, 1: 1 = write, 0 = read.
REQ-010 Port sel, input, SEL_W: target slave index.
REQ-011 Port addr, input, ADDR_W: transfer address.
REQ-012 Port wdata, input, DATA_W: write data.
REQ-013 Port wait_cycles, input, WAIT_W: minimum ACCESS cycles before pready is honoured.
REQ-014 Port rdata, output, DATA_W: read data, held until the next read completes.
REQ-015 Port stable, output, 1: one-cycle completion pulse.
REQ-016 Port error, output, 1: completion status, valid while stable=1.
REQ-017 Port psel, output, NUM_SLV: one-hot slave select.
REQ-018 Port penable, output, 1: APB access phase.
REQ-019 Port pwrite/paddr/pwdata, output, 1/ADDR_W/DATA_W: registered request fields.
REQ-020 Port prdata_vec, input, NUM_SLV*DATA_W: slave i read data at bits [i*DATA_W +: DATA_W].
REQ-021 Port pready_vec/pslverr_vec, input, NUM_SLV each: per-slave ready and error.

Function
REQ-022 FSM states IDLE, SETUP, ACCESS, DONE.
REQ-023 IDLE with start=1: latch write/sel/addr/wdata/wait_cycles, go to SETUP next cycle; start outside IDLE is ignored.
REQ-024 SETUP lasts exactly one cycle: psel[sel]=1, penable=0; then ACCESS.
REQ-025 ACCESS: psel[sel]=1, penable=1; wait counter starts at 0 and increments each ACCESS cycle, saturating at all-ones.
REQ-026 ACCESS exits to DONE in the first cycle where count >= wait_cycles and pready_vec[sel]=1; wait_cycles=0 means the first ACCESS cycle may complete.
REQ-027 On ACCESS exit, a read captures prdata_vec slice sel into rdata; error captures pslverr_vec[sel]; a write leaves rdata unchanged.
REQ-028 DONE lasts one cycle: stable=1, psel=0, penable=0; then IDLE. Minimum latency from start to stable is 3 cycles.
REQ-029 sel >= NUM_SLV: no psel bit is asserted; the FSM goes SETUP->DONE with error=1 and rdata unchanged.
REQ-030 pready from non-selected slaves is ignored.
REQ-031 paddr/pwrite/pwdata stay constant from SETUP through ACCESS exit.

Reset
REQ-032 reset=1 at a clock edge forces IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rdata=0, stable=0, error=0, counter=0; this applies mid-transfer with no completion pulse.
REQ-033 reset has priority over start in the same cycle.

Configuration
REQ-034 Macro APB_BRIDGE_TIMEOUT_EN defined: if ACCESS has lasted TIMEOUT_CYC cycles without completing, exit to DONE with error=1 and rdata unchanged.
REQ-035 Macro APB_BRIDGE_TIMEOUT_EN absent: ACCESS waits indefinitely for pready, and no timeout logic is present.

Structure
REQ-036 Package apb_pkg holds the state enum apb_state_t and the default parameter constants.
REQ-037 Sub-module apb_wait_timer holds the saturating ACCESS counter and the threshold/timeout compare; apb_bridge_n instantiates it once.

Verification
REQ-038 Write: sel=2, addr=0x10, wdata=0xA5, wait_cycles=0, slave 2 pready=1 -> psel=4'b0100; SETUP then one ACCESS cycle; stable at cycle 3, error=0.
REQ-039 Read: sel=1, wait_cycles=3, pready=1 throughout, slave 1 prdata=0x3C -> 4 ACCESS cycles; rdata=0x3C; stable=1 for 1 cycle.
REQ-040 Slave 0 pready held low for 10 ACCESS cycles while slave 3 pready=1, with pslverr=1 on release -> completes after the 11th cycle; error=1.
REQ-041 NUM_SLV=3, sel=3 -> psel stays 0; stable with error=1 two cycles after start.
REQ-042 reset asserted during ACCESS of a read -> next cycle all outputs are 0; no stable pulse; a new start then completes normally.
REQ-043 With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=64, pready held low -> stable and error=1 after 64 ACCESS cycles; without the macro, no completion.
